// File: rtl/fetch_stage_if.sv
// fetch_stage_if: control, redirect, imem and IF/ID signals of the fetch stage
interface fetch_stage_if #(parameter int DATA_WIDTH = 32);
  logic stall, flush, PCSrc, jalr_en, valid_d, halted, misalign;
  logic [DATA_WIDTH-1:0] ImmExt, jalr_target, instr_i, PC, instr_d, pc_d, pc_plus4_d;
  logic [31:0] fetch_count;
  modport master (
    output stall, flush, PCSrc, ImmExt, jalr_en, jalr_target, instr_i,
    input PC, instr_d, pc_d, pc_plus4_d, valid_d, halted, misalign, fetch_count
  );
  modport slave (
    input stall, flush, PCSrc, ImmExt, jalr_en, jalr_target, instr_i,
    output PC, instr_d, pc_d, pc_plus4_d, valid_d, halted, misalign, fetch_count
  );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: RV32I PC / next-PC select / IF-ID register; FETCH_MISALIGN_TRAP_EN halts on misaligned redirect targets
module fetch_stage #(
  parameter int DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC = 32'hBFC0_0000
) (
  input logic clk,
  input logic rst,
  fetch_stage_if.slave f
);
  typedef enum logic {RUN, HALT} state_t;
  state_t state;
  logic redirect, squash;
  logic [DATA_WIDTH-1:0] seq, target, next_pc;
  assign seq = f.PC + DATA_WIDTH'(4);
  // redirects come from the decode-stage instruction, so a bubble there cannot redirect
  assign redirect = f.valid_d & (f.jalr_en | f.PCSrc);
  assign target = f.jalr_en ? (f.jalr_target & ~DATA_WIDTH'(1)) : f.pc_d + f.ImmExt;
  assign squash = f.flush | redirect;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic bad;
  assign bad = redirect & (|target[1:0]);
  assign next_pc = redirect ? target : seq;
`else
  assign next_pc = redirect ? (target & ~DATA_WIDTH'(3)) : seq;
  assign f.misalign = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      f.PC <= RESET_PC;
      f.instr_d <= '0;
      f.pc_d <= '0;
      f.pc_plus4_d <= '0;
      f.valid_d <= 1'b0;
      f.halted <= 1'b0;
      f.fetch_count <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
      f.misalign <= 1'b0;
`endif
    end else if (state == RUN) begin
      if (f.stall) begin
        if (f.flush) f.valid_d <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
      end else if (bad) begin
        state <= HALT;
        f.halted <= 1'b1;
        f.misalign <= 1'b1;
        f.valid_d <= 1'b0;
`endif
      end else begin
        f.PC <= next_pc;
        f.instr_d <= f.instr_i;
        f.pc_d <= f.PC;
        f.pc_plus4_d <= seq;
        f.valid_d <= !squash;
        if (!squash) f.fetch_count <= f.fetch_count + 32'd1;
      end
    end
  end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed self-checking bench for fetch_stage
module tb_fetch_stage;
  logic clk = 1'b0;
  logic rst;
  int n_chk = 0;
  int n_err = 0;
  fetch_stage_if #(.DATA_WIDTH(32)) fi();
  fetch_stage #(.DATA_WIDTH(32), .RESET_PC(32'hBFC0_0000)) dut (.clk(clk), .rst(rst), .f(fi.slave));
  always #5 clk = ~clk;
  assign fi.instr_i = ~fi.PC;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic quiet();
    fi.stall = 0; fi.flush = 0; fi.PCSrc = 0; fi.jalr_en = 0; fi.ImmExt = 0; fi.jalr_target = 0;
  endtask
  task automatic reset_checks(input string tag);
    check({tag, "_pc"}, fi.PC, 32'hBFC0_0000);
    check({tag, "_valid"}, {31'd0, fi.valid_d}, 0);
    check({tag, "_count"}, fi.fetch_count, 0);
    check({tag, "_pcd"}, fi.pc_d, 0);
    check({tag, "_instr"}, fi.instr_d, 0);
    check({tag, "_p4"}, fi.pc_plus4_d, 0);
    check({tag, "_halt"}, {31'd0, fi.halted}, 0);
    check({tag, "_mis"}, {31'd0, fi.misalign}, 0);
  endtask
  initial begin
    quiet();
    rst = 1;
    step();
    reset_checks("rst");
    rst = 0;
    step();
    check("seq1_pc", fi.PC, 32'hBFC0_0004);
    check("seq1_valid", {31'd0, fi.valid_d}, 1);
    step();
    check("seq2_pc", fi.PC, 32'hBFC0_0008);
    step();
    check("seq3_pc", fi.PC, 32'hBFC0_000C);
    check("seq3_count", fi.fetch_count, 3);
    check("seq3_pcd", fi.pc_d, 32'hBFC0_0008);
    check("seq3_instr", fi.instr_d, ~32'hBFC0_0008);
    check("seq3_p4", fi.pc_plus4_d, 32'hBFC0_000C);
    // JALR beats a simultaneous branch and clears bit 0
    fi.jalr_en = 1; fi.jalr_target = 32'h101; fi.PCSrc = 1; fi.ImmExt = 32'h40;
    step();
    check("jalr_pc", fi.PC, 32'h100);
    check("jalr_valid", {31'd0, fi.valid_d}, 0);
    check("jalr_count", fi.fetch_count, 3);
    quiet();
    step();
    check("t100_pcd", fi.pc_d, 32'h100);
    check("t100_valid", {31'd0, fi.valid_d}, 1);
    fi.PCSrc = 1; fi.ImmExt = 32'hFFFF_FFF0;
    step();
    check("br_pc", fi.PC, 32'hF0);
    check("br_valid", {31'd0, fi.valid_d}, 0);
    check("br_count", fi.fetch_count, 4);
    step();
    check("brbub_pc", fi.PC, 32'hF4);
    check("brbub_pcd", fi.pc_d, 32'hF0);
    check("brbub_instr", fi.instr_d, ~32'hF0);
    check("brbub_valid", {31'd0, fi.valid_d}, 1);
    check("brbub_count", fi.fetch_count, 5);
    quiet();
    fi.stall = 1; fi.jalr_en = 1; fi.jalr_target = 32'h400;
    step();
    check("st1_pc", fi.PC, 32'hF4);
    check("st1_valid", {31'd0, fi.valid_d}, 1);
    fi.jalr_en = 0; fi.flush = 1;
    step();
    check("st2_pc", fi.PC, 32'hF4);
    check("st2_valid", {31'd0, fi.valid_d}, 0);
    check("st2_pcd", fi.pc_d, 32'hF0);
    fi.flush = 0;
    step();
    check("st3_pc", fi.PC, 32'hF4);
    check("st3_count", fi.fetch_count, 5);
    fi.stall = 0;
    step();
    check("res_pc", fi.PC, 32'hF8);
    check("res_pcd", fi.pc_d, 32'hF4);
    check("res_valid", {31'd0, fi.valid_d}, 1);
    check("res_count", fi.fetch_count, 6);
    fi.flush = 1;
    step();
    check("fl_pc", fi.PC, 32'hFC);
    check("fl_valid", {31'd0, fi.valid_d}, 0);
    check("fl_count", fi.fetch_count, 6);
    fi.flush = 0;
    step();
    check("post_fl_count", fi.fetch_count, 7);
    fi.jalr_en = 1; fi.jalr_target = 32'hFFFF_FFFD;
    step();
    check("top_pc", fi.PC, 32'hFFFF_FFFC);
    quiet();
    step();
    check("wrap_pc", fi.PC, 32'h0);
    check("wrap_pcd", fi.pc_d, 32'hFFFF_FFFC);
    check("wrap_p4", fi.pc_plus4_d, 32'h0);
    check("wrap_count", fi.fetch_count, 8);
    fi.stall = 1;
    rst = 1;
    step();
    reset_checks("rst_stall");
    rst = 0;
    quiet();
    step();
`ifdef FETCH_MISALIGN_TRAP_EN
    fi.jalr_en = 1; fi.jalr_target = 32'h203; fi.PCSrc = 1;
    step();
    check("trap_pc", fi.PC, 32'hBFC0_0004);
    check("trap_halt", {31'd0, fi.halted}, 1);
    check("trap_mis", {31'd0, fi.misalign}, 1);
    check("trap_valid", {31'd0, fi.valid_d}, 0);
    quiet();
    step();
    check("halt_pc", fi.PC, 32'hBFC0_0004);
    check("halt_count", fi.fetch_count, 1);
    rst = 1;
    step();
    reset_checks("rst_halt");
    rst = 0;
`else
    fi.PCSrc = 1; fi.ImmExt = 32'h6;
    step();
    check("align_pc", fi.PC, 32'hBFC0_0004);
    check("align_halt", {31'd0, fi.halted}, 0);
    check("align_mis", {31'd0, fi.misalign}, 0);
    quiet();
    step();
    check("align_next", fi.PC, 32'hBFC0_0008);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
